// File: rtl/maint_pkg.sv
// Shared types and helpers for the maintenance scheduler: scrub FSM states
// and the risk-level to interval-shift mapping.
package maint_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } scrub_state_t;

  // Each risk step halves the patrol-scrub interval.
  function automatic int unsigned risk_shift(input logic [1:0] risk);
    return 32'(risk);
  endfunction

endpackage

// File: rtl/refresh_debt_tracker.sv
// tREFI interval counter plus refresh debt bookkeeping (owed, urgent, overflow).
// Optional MAINT_STATS_EN adds an acknowledged-refresh counter.
module refresh_debt_tracker #(
  parameter int TREFI        = 7800,
  parameter int MAX_POSTPONE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_idle,
  input  logic        refresh_ack,
  output logic        refresh_req,
  output logic        refresh_urgent,
  output logic        refresh_overflow,
  output logic [31:0] stat_ref_cnt
);

  localparam int RW = $clog2(TREFI);
  localparam int OW = $clog2(MAX_POSTPONE + 1);
  localparam logic [RW-1:0] RELOAD   = RW'(TREFI - 1);
  localparam logic [OW-1:0] OWED_MAX = OW'(MAX_POSTPONE);

  logic [RW-1:0] ref_cnt;
  logic [OW-1:0] owed;
  logic          tick;
  logic          ack_valid;

  assign tick      = (ref_cnt == '0);
  // An ack with nothing owed must not underflow the debt.
  assign ack_valid = refresh_ack && (owed != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt          <= RELOAD;
      owed             <= '0;
      refresh_overflow <= 1'b0;
    end else begin
      ref_cnt <= tick ? RELOAD : ref_cnt - 1'b1;
      if (tick && !ack_valid) begin
        if (owed == OWED_MAX) refresh_overflow <= 1'b1;
        else                  owed             <= owed + 1'b1;
      end else if (ack_valid && !tick) begin
        owed <= owed - 1'b1;
      end
    end
  end

  assign refresh_urgent = (owed == OWED_MAX);
  assign refresh_req    = (owed != '0) && (bus_idle || refresh_urgent);

`ifdef MAINT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stat_ref_cnt <= '0;
    else if (ack_valid) stat_ref_cnt <= stat_ref_cnt + 32'd1;
  end
`else
  assign stat_ref_cnt = '0;
`endif

endmodule

// File: rtl/maint_scheduler.sv
// Refresh/scrub request generator feeding the command arbiter.
// Optional MAINT_STATS_EN enables the acknowledged refresh/scrub counters.
module maint_scheduler
  import maint_pkg::*;
#(
  parameter int TREFI               = 7800,
  parameter int MAX_POSTPONE        = 8,
  parameter int SCRUB_BASE_INTERVAL = 65536,
  parameter int SCRUB_ROWS          = 1024,
  parameter int SCRUB_STEP          = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_idle,
  input  logic        refresh_ack,
  input  logic        scrub_ack,
  input  logic        scrub_en,
  input  logic [1:0]  risk_level,
  output logic        refresh_req,
  output logic        refresh_urgent,
  output logic        refresh_overflow,
  output logic        scrub_req,
  output logic [31:0] scrub_addr,
  output logic [31:0] stat_ref_cnt,
  output logic [31:0] stat_scrub_cnt
);

  // One spare bit: the counter may step to the full interval on the S_PEND edge.
  localparam int CW   = $clog2(SCRUB_BASE_INTERVAL) + 1;
  localparam int RWID = (SCRUB_ROWS > 1) ? $clog2(SCRUB_ROWS) : 1;
  localparam logic [RWID-1:0] ROW_LAST = RWID'(SCRUB_ROWS - 1);

  scrub_state_t  state, state_next;
  logic [CW-1:0]   scrub_cnt, scrub_cnt_next, interval;
  logic [RWID-1:0] scrub_row, scrub_row_next;

  refresh_debt_tracker #(
    .TREFI        (TREFI),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_refresh (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus_idle         (bus_idle),
    .refresh_ack      (refresh_ack),
    .refresh_req      (refresh_req),
    .refresh_urgent   (refresh_urgent),
    .refresh_overflow (refresh_overflow),
    .stat_ref_cnt     (stat_ref_cnt)
  );

  assign interval = CW'(SCRUB_BASE_INTERVAL) >> risk_shift(risk_level);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    scrub_cnt_next = scrub_cnt;
    scrub_row_next = scrub_row;
    scrub_req      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!scrub_en) begin
          scrub_cnt_next = '0;
        end else begin
          scrub_cnt_next = scrub_cnt + 1'b1;
          if (scrub_cnt >= interval - 1'b1) state_next = S_PEND;
        end
      end
      S_PEND: begin
        // A forced refresh owns the bus; hold the scrub back until it clears.
        scrub_req = !refresh_urgent;
        if (scrub_ack) begin
          scrub_cnt_next = '0;
          scrub_row_next = (scrub_row == ROW_LAST) ? '0 : scrub_row + 1'b1;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      scrub_cnt <= '0;
      scrub_row <= '0;
    end else begin
      state     <= state_next;
      scrub_cnt <= scrub_cnt_next;
      scrub_row <= scrub_row_next;
    end
  end

  assign scrub_addr = 32'(scrub_row) * 32'(SCRUB_STEP);

`ifdef MAINT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stat_scrub_cnt <= '0;
    else if (state == S_PEND && scrub_ack)  stat_scrub_cnt <= stat_scrub_cnt + 32'd1;
  end
`else
  assign stat_scrub_cnt = '0;
`endif

endmodule

// File: tb/tb_maint_scheduler.sv
// Directed bench for maint_scheduler with small parameters: a refresh vector
// table followed by hand-written scrub, masking and reset sequences.
module tb_maint_scheduler;

  localparam int TREFI = 16;
  localparam int MAXP  = 2;
  localparam int SBASE = 64;
  localparam int SROWS = 4;
  localparam int SSTEP = 64;
`ifdef MAINT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_idle = 1'b0;
  logic        ack_man = 1'b0;
  logic        ack_auto = 1'b0;
  logic        auto_en = 1'b0;
  logic        refresh_ack;
  logic        scrub_ack = 1'b0;
  logic        scrub_en = 1'b0;
  logic [1:0]  risk_level = 2'd0;
  logic        refresh_req, refresh_urgent, refresh_overflow, scrub_req;
  logic [31:0] scrub_addr, stat_ref_cnt, stat_scrub_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  assign refresh_ack = ack_man | ack_auto;

  always #5 clk = ~clk;

  maint_scheduler #(
    .TREFI               (TREFI),
    .MAX_POSTPONE        (MAXP),
    .SCRUB_BASE_INTERVAL (SBASE),
    .SCRUB_ROWS          (SROWS),
    .SCRUB_STEP          (SSTEP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus_idle         (bus_idle),
    .refresh_ack      (refresh_ack),
    .scrub_ack        (scrub_ack),
    .scrub_en         (scrub_en),
    .risk_level       (risk_level),
    .refresh_req      (refresh_req),
    .refresh_urgent   (refresh_urgent),
    .refresh_overflow (refresh_overflow),
    .scrub_req        (scrub_req),
    .scrub_addr       (scrub_addr),
    .stat_ref_cnt     (stat_ref_cnt),
    .stat_scrub_cnt   (stat_scrub_cnt)
  );

  // Background arbiter stand-in: accepts any visible refresh request.
  initial forever begin
    @(negedge clk);
    ack_auto = auto_en && refresh_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".refresh_req"},      {31'd0, refresh_req},      32'd0);
    check({tag, ".refresh_urgent"},   {31'd0, refresh_urgent},   32'd0);
    check({tag, ".refresh_overflow"}, {31'd0, refresh_overflow}, 32'd0);
    check({tag, ".scrub_req"},        {31'd0, scrub_req},        32'd0);
    check({tag, ".scrub_addr"},       scrub_addr,                32'd0);
    check({tag, ".stat_ref_cnt"},     stat_ref_cnt,              32'd0);
    check({tag, ".stat_scrub_cnt"},   stat_scrub_cnt,            32'd0);
  endtask

  typedef struct {
    int cycles;
    bit idle;
    bit ack;
    bit e_req;
    bit e_urg;
    bit e_ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Edge counts E are relative to reset release; ticks land on E = 16k.
    vecs.push_back('{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}); // E=15 no debt yet
    vecs.push_back('{ 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}); // E=16 owed=1
    vecs.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}); // E=17 ack -> owed=0
    vecs.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}); // E=18 ack at owed=0 ignored
    vecs.push_back('{14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}); // E=32 owed=1, bus busy
    vecs.push_back('{15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}); // E=47
    vecs.push_back('{ 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}); // E=48 owed=2 urgent
    vecs.push_back('{15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}); // E=63
    vecs.push_back('{ 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}); // E=64 tick at max -> overflow
    vecs.push_back('{ 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}); // E=65 owed=1
    vecs.push_back('{ 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}); // bus idle shows the debt
    vecs.push_back('{14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}); // E=79
    vecs.push_back('{ 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}); // E=80 tick+ack -> owed=1
    vecs.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}); // E=81 owed=0

    // Reset state, held across clock edges.
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus_idle = vecs[i].idle;
      ack_man  = vecs[i].ack;
      step(vecs[i].cycles);
      #1;
      check($sformatf("vec%0d.refresh_req", i),      {31'd0, refresh_req},      {31'd0, vecs[i].e_req});
      check($sformatf("vec%0d.refresh_urgent", i),   {31'd0, refresh_urgent},   {31'd0, vecs[i].e_urg});
      check($sformatf("vec%0d.refresh_overflow", i), {31'd0, refresh_overflow}, {31'd0, vecs[i].e_ovf});
      check($sformatf("vec%0d.scrub_req", i),        {31'd0, scrub_req},        32'd0);
    end
    ack_man = 1'b0;
    check("table.stat_ref_cnt", stat_ref_cnt, STATS ? 32'd4 : 32'd0);

    // Scrub walk at risk 0 with refreshes serviced in the background.
    bus_idle = 1'b1;
    scrub_en = 1'b1;
    risk_level = 2'd0;
    auto_en = 1'b1;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        step(30);
        scrub_ack = 1'b1;   // ack while idle must be ignored
        step(1);
        scrub_ack = 1'b0;
        step(32);
      end else begin
        step(63);
      end
      check($sformatf("scrub%0d.early", k), {31'd0, scrub_req}, 32'd0);
      step(1);
      check($sformatf("scrub%0d.req", k),  {31'd0, scrub_req}, 32'd1);
      check($sformatf("scrub%0d.addr", k), scrub_addr, 32'((k % SROWS) * SSTEP));
      scrub_ack = 1'b1;
      step(1);
      scrub_ack = 1'b0;
      check($sformatf("scrub%0d.done", k),      {31'd0, scrub_req}, 32'd0);
      check($sformatf("scrub%0d.next_addr", k), scrub_addr, 32'(((k + 1) % SROWS) * SSTEP));
    end

    // E=325: counter restarted. Raise risk with scrub_cnt=10 (> new interval 8).
    step(10);
    risk_level = 2'd3;
    #1;
    check("risk.before_edge", {31'd0, scrub_req}, 32'd0);
    step(1);                  // E=336, refresh tick gives owed=1
    check("risk.pend", {31'd0, scrub_req}, 32'd1);
    auto_en  = 1'b0;
    scrub_en = 1'b0;          // must not cancel the pending scrub
    step(15);                 // E=351
    check("mask.before.scrub_req", {31'd0, scrub_req},      32'd1);
    check("mask.before.urgent",    {31'd0, refresh_urgent}, 32'd0);
    step(1);                  // E=352, owed=2
    check("mask.urgent",      {31'd0, refresh_urgent}, 32'd1);
    check("mask.scrub_req",   {31'd0, scrub_req},      32'd0);
    check("mask.refresh_req", {31'd0, refresh_req},    32'd1);
    check("mask.scrub_addr",  scrub_addr,              32'd64);
    check("mask.stat_scrub_cnt", stat_scrub_cnt, STATS ? 32'd5 : 32'd0);
    check("mask.stat_ref_cnt",   stat_ref_cnt,   STATS ? 32'd20 : 32'd0);

    // Reset mid-operation: outputs clear without waiting for a clock edge.
    risk_level = 2'd0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step(1);
    rst_n = 1'b1;
    step(15);
    check("rerelease.early", {31'd0, refresh_req}, 32'd0);
    check("rerelease.scrub", {31'd0, scrub_req},   32'd0);
    step(1);
    check("rerelease.req",   {31'd0, refresh_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maint_scheduler.md
Name: maint_scheduler

Overview:
Generates the refresh_req and scrub_req levels that the command arbiter consumes, so the arbiter no longer needs a free-running refresh timer or an ad-hoc scrub source.
- Refresh: tracks refresh debt in tREFI units and postpones refreshes while the command path is busy, up to a bound. At the bound the refresh becomes urgent and is issued regardless of traffic.
- Scrub: issues patrol-scrub requests at an interval scaled by the ML risk level. Walks a scrub address across the array.

Parameters:
TREFI, 7800, refresh interval in clk cycles (>=2)
MAX_POSTPONE, 8, maximum refresh debt before refresh is forced (>=1)
SCRUB_BASE_INTERVAL, 65536, scrub interval in cycles at risk_level 0 (power of two, >=16)
SCRUB_ROWS, 1024, number of scrub positions before the walk wraps
SCRUB_STEP, 64, address increment per scrub

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
bus_idle  in  1  command FIFO empty and no arbiter output pending
refresh_ack  in  1  one-cycle pulse: arbiter accepted a CMD_REFRESH
scrub_ack  in  1  one-cycle pulse: arbiter accepted a CMD_SCRUB
scrub_en  in  1  enables scrub scheduling
risk_level  in  2  ML error-risk class, 0=low .. 3=high
refresh_req  out  1  refresh request level to arbiter
refresh_urgent  out  1  debt has reached MAX_POSTPONE
refresh_overflow  out  1  sticky: a tREFI tick arrived while debt was at MAX_POSTPONE
scrub_req  out  1  scrub request level to arbiter
scrub_addr  out  32  address of the pending or next scrub
stat_ref_cnt  out  32  refreshes acknowledged (see Optional Feature)
stat_scrub_cnt  out  32  scrubs acknowledged (see Optional Feature)

Behaviour:
- Single clock, clk. Asynchronous active-low reset, rst_n.
- Reset values:
  - all outputs 0; refresh_overflow cleared only by reset
  - ref_cnt = TREFI-1, owed = 0
  - scrub FSM in S_IDLE, scrub_cnt = 0, scrub_row = 0
- Refresh interval counter:
  - ref_cnt decrements every cycle.
  - At 0 it reloads TREFI-1 and produces a tick in that cycle.
- Refresh debt register owed, width clog2(MAX_POSTPONE+1), is updated each edge:
  - tick and no valid ack: owed+1, saturating at MAX_POSTPONE. A tick at MAX_POSTPONE sets refresh_overflow.
  - valid ack and no tick: owed-1.
  - tick and valid ack together: owed unchanged.
  - A refresh_ack while owed==0 is not a valid ack and is ignored.
- Refresh outputs are combinational from registered owed:
  - refresh_urgent = (owed == MAX_POSTPONE)
  - refresh_req = (owed != 0) && (bus_idle || refresh_urgent)
  - The first request appears TREFI cycles after reset release.
- Scrub interval:
  - interval = SCRUB_BASE_INTERVAL >> risk_level, evaluated every cycle.
  - A risk_level change takes effect immediately. If scrub_cnt is already >= the new interval, the FSM enters S_PEND at the next edge.
- Scrub FSM, S_IDLE:
  - If scrub_en=0: scrub_cnt held at 0.
  - Else scrub_cnt increments each cycle.
  - When scrub_cnt >= interval-1, go to S_PEND.
- Scrub FSM, S_PEND:
  - scrub_req = !refresh_urgent, so scrubs are masked while a refresh is forced.
  - scrub_cnt is held.
  - On scrub_ack: scrub_cnt<=0; scrub_row <= (scrub_row==SCRUB_ROWS-1) ? 0 : scrub_row+1; return to S_IDLE.
  - scrub_en dropping in S_PEND does not cancel the pending scrub.
- Ack outside S_PEND: scrub_ack in S_IDLE is ignored.
- scrub_addr = scrub_row * SCRUB_STEP, truncated to 32 bits.
- Reset mid-operation discards all debt and any pending scrub.

Optional Feature:
- Macro: MAINT_STATS_EN.
- Defined: stat_ref_cnt increments on each valid refresh_ack; stat_scrub_cnt increments on each scrub_ack accepted in S_PEND. Both are 32-bit, wrap at 2^32, and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- maint_pkg holds the scrub FSM state enum (S_IDLE, S_PEND) and a risk-to-shift helper function.
- Command encodings stay in cmd_defs.
- One sub-module, refresh_debt_tracker, covers the interval counter, owed, urgent and overflow logic. Scrub logic stays in the top module.

Test Plan (TREFI=16, MAX_POSTPONE=2, SCRUB_BASE_INTERVAL=64, SCRUB_ROWS=4, SCRUB_STEP=64):
1. Release reset, bus_idle=1, no acks -> refresh_req rises 16 cycles after release (owed=1); pulse refresh_ack -> owed=0 and refresh_req low the next cycle.
2. bus_idle=0, no acks for 50 cycles -> refresh_req stays 0 at owed=1; refresh_urgent=1 and refresh_req=1 once owed=2 (cycle 32); at cycle 48 refresh_overflow=1 and owed stays 2.
3. owed=1, refresh_ack in the same cycle as a tick -> owed remains 1; refresh_ack with owed=0 -> owed stays 0.
4. scrub_en=1, risk_level=0, ack each request -> scrub_req every 64 cycles; scrub_addr sequence 0, 64, 128, 192, 0.
5. risk_level 0->3 when scrub_cnt=10 -> S_PEND next edge, scrub_req=1; force refresh_urgent=1 -> scrub_req=0 while urgent.
6. Assert rst_n low while scrub pending and owed=2 -> all outputs 0 immediately; after release, refresh_req first appears 16 cycles later.
